memctrl_rr: RTL and testbench

Parametrised successor memory controller: arbitrates NUM_CH requesters (icache, LSB, future DMA/debug ports) onto the single byte-serial RAM/IO bus with round-robin fairness. Performs byte, half and word loads and stores with optional sign extension, a load-abort flush, and optional I/O back-pressure. Sits between the requesters and the top-level `mem_*` pins.

---
 rtl/memctrl_pkg.sv | 33 +++
 rtl/memctrl_rr_arbiter.sv | 33 +++
 rtl/memctrl_rr.sv | 170 +++++++++++++++++
 tb/tb_memctrl_rr.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared encodings and helpers for the round-robin memory controller.
package memctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

    // Memory-mapped I/O window that can apply back-pressure to stores
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam int          IO_SPAN = 8;

    // Number of bus bytes for a size code; the illegal code 3 is treated as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Zero- or sign-extend an assembled load from its top byte
    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] sz,
                                                input logic sgn);
        case (sz)
            SZ_BYTE: return {{24{sgn & d[7]}}, d[7:0]};
            SZ_HALF: return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/memctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; scans from ptr+1 and wraps.
// The pointer register is owned by the controller.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic found;
    int   c;

    // First requesting channel after the last winner gets the grant
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr) + 1 + i) % NUM_CH;
            if (en && !found && req[c]) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/memctrl_rr.sv
// memctrl_rr: round-robin arbitration of NUM_CH requesters onto the byte-serial
// RAM/IO bus. Byte/half/word loads and stores, load flush, rdy_in freeze.
// Optional MEMCTRL_IO_STALL_EN adds io_buffer_full, which holds off store bytes
// aimed at the I/O window until the buffer drains.
module memctrl_rr
    import memctrl_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [ADDR_W-1:0]              mem_a,
    output logic                           mem_wr,
    input  logic [NUM_CH-1:0]              req_valid,
    input  logic [NUM_CH-1:0]              req_we,
    input  logic [NUM_CH-1:0][1:0]         req_size,
    input  logic [NUM_CH-1:0]              req_signed,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CH-1:0][31:0]        req_wdata,
    output logic [NUM_CH-1:0]              req_ready,
    output logic [NUM_CH-1:0]              resp_valid,
    output logic [31:0]                    resp_data,
    input  logic                           flush_in
`ifdef MEMCTRL_IO_STALL_EN
    ,input logic                           io_buffer_full
`endif
);

    state_e             state;
    logic [IDX_W-1:0]   ptr;        // last granted channel, doubles as current owner
    logic               lat_we;
    logic               lat_signed;
    logic [1:0]         lat_size;
    logic [ADDR_W-1:0]  lat_addr;
    logic [31:0]        lat_wdata;
    logic [31:0]        rbuf;       // load bytes gathered so far
    logic [2:0]         cnt;        // edges spent in XFER (issue index / capture offset)

    logic [NUM_CH-1:0]  gnt;
    logic [NUM_CH-1:0]  ch_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic [2:0]         nb;
    logic [ADDR_W-1:0]  cur_addr;
    logic [1:0]         cap_bi;
    logic [31:0]        ld_word;
    logic               stall;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign nb       = size_bytes(lat_size);
    assign cur_addr = lat_addr + ADDR_W'(cnt);
    // Byte k is on mem_din two edges after its address was registered
    assign cap_bi   = 2'(cnt - 3'd2);

    // Load word with the byte arriving this cycle merged in
    always_comb begin
        ld_word = rbuf;
        ld_word[{cap_bi, 3'b000} +: 8] = mem_din;
    end

    // One-hot of the channel currently being served
    always_comb begin
        ch_oh      = '0;
        ch_oh[ptr] = 1'b1;
    end

`ifdef MEMCTRL_IO_STALL_EN
    logic [ADDR_W-1:0] io_off;
    assign io_off = cur_addr - ADDR_W'(IO_BASE);
    assign stall  = io_buffer_full && (io_off < ADDR_W'(IO_SPAN));
`else
    assign stall  = 1'b0;
`endif

    // Controller FSM with registered bus and handshake outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_CH - 1);
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rbuf       <= '0;
            cnt        <= '0;
            mem_dout   <= '0;
            mem_a      <= '0;
            mem_wr     <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else if (rdy_in) begin
            req_ready  <= '0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    mem_wr   <= 1'b0;
                    mem_a    <= '0;
                    mem_dout <= '0;
                    if (|req_valid) begin
                        req_ready  <= gnt;
                        ptr        <= gnt_idx;
                        lat_we     <= req_we[gnt_idx];
                        lat_size   <= req_size[gnt_idx];
                        lat_signed <= req_signed[gnt_idx];
                        lat_addr   <= req_addr[gnt_idx];
                        lat_wdata  <= req_wdata[gnt_idx];
                        rbuf       <= '0;
                        cnt        <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (lat_we) begin
                        // Stores ignore flush and always complete
                        if (cnt == nb) begin
                            mem_wr     <= 1'b0;
                            mem_a      <= '0;
                            mem_dout   <= '0;
                            resp_valid <= ch_oh;
                            resp_data  <= '0;
                            state      <= RESP;
                        end else if (stall) begin
                            mem_wr   <= 1'b0;
                            mem_a    <= '0;
                            mem_dout <= '0;
                        end else begin
                            mem_wr   <= 1'b1;
                            mem_a    <= cur_addr;
                            mem_dout <= lat_wdata[{cnt[1:0], 3'b000} +: 8];
                            cnt      <= cnt + 3'd1;
                        end
                    end else if (flush_in) begin
                        mem_a <= '0;
                        state <= IDLE;
                    end else begin
                        mem_wr <= 1'b0;
                        mem_a  <= (cnt < nb) ? cur_addr : '0;
                        if (cnt >= 3'd2)
                            rbuf <= ld_word;
                        if (cnt == nb + 3'd1) begin
                            resp_valid <= ch_oh;
                            resp_data  <= load_extend(ld_word, lat_size, lat_signed);
                            state      <= RESP;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    resp_data <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memctrl_rr.sv
// tb_memctrl_rr: randomized and directed checks of memctrl_rr against a
// byte-array memory model and a transaction-level reference.
module tb_memctrl_rr;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;

    logic                          clk_in = 1'b0;
    logic                          rst_in, rdy_in, flush_in;
    logic [7:0]                    mem_din, mem_dout;
    logic [ADDR_W-1:0]             mem_a;
    logic                          mem_wr;
    logic [NUM_CH-1:0]             req_valid, req_we, req_signed, req_ready, resp_valid;
    logic [NUM_CH-1:0][1:0]        req_size;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0][31:0]       req_wdata;
    logic [31:0]                   resp_data;
`ifdef MEMCTRL_IO_STALL_EN
    logic                          io_buffer_full;
`endif

    memctrl_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .req_valid(req_valid),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush_in(flush_in)
`ifdef MEMCTRL_IO_STALL_EN
        , .io_buffer_full(io_buffer_full)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0;
    int cyc = 0;
    int last_gnt;
    bit ram_ready = 1'b0;
    logic [7:0]  ram    [0:262143];
    logic [7:0]  shadow [0:262143];
    logic [31:0] log_a  [0:4095];
    logic        log_wr [0:4095];
    logic [7:0]  log_d  [0:4095];

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 73) ^ (i >> 7) ^ 8'h5C);
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    // Reference load: gather bytes from the model memory, then extend arithmetically
    function automatic logic [31:0] model_load(logic [31:0] addr, logic [1:0] sz, bit sg);
        int n;
        logic [63:0] v;
        logic [31:0] a;
        n = nbytes(sz);
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (64'(shadow[a[17:0]]) << (8 * i));
        end
        if (sg && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    function automatic void model_store(logic [31:0] addr, logic [1:0] sz, logic [31:0] wd);
        logic [31:0] a;
        for (int i = 0; i < nbytes(sz); i++) begin
            a = addr + 32'(i);
            shadow[a[17:0]] = wd[8*i +: 8];
        end
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous RAM: address in cycle t, data on mem_din in t+1
    always @(posedge clk_in) begin
        if (!ram_ready) begin
            for (int i = 0; i < 262144; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        end
    end

    always @(negedge clk_in) begin
        log_a[cyc % 4096]  <= mem_a;
        log_wr[cyc % 4096] <= mem_wr;
        log_d[cyc % 4096]  <= mem_dout;
    end

    task automatic do_txn(input int ch, input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int a, output int r, output logic [31:0] d);
        a = -1; r = -1; d = '0;
        req_valid[ch] = 1'b1; req_we[ch] = we; req_size[ch] = sz;
        req_signed[ch] = sg; req_addr[ch] = addr; req_wdata[ch] = wd;
        for (int k = 0; k < 60 && a < 0; k++) begin
            @(negedge clk_in);
            if (req_ready[ch]) a = cyc;
        end
        req_valid[ch] = 1'b0;
        if (a < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout ch=%0d got=none want=req_ready", ch);
            return;
        end
        last_gnt = ch;
        for (int k = 0; k < 60 && r < 0; k++) begin
            @(negedge clk_in);
            if (resp_valid[ch]) begin r = cyc; d = resp_data; end
        end
        if (r < 0) begin
            total++; bad++;
            $display("FAIL resp_timeout ch=%0d got=none want=resp_valid", ch);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; req_valid = '1;
        repeat (3) @(negedge clk_in);
        total++;
        if ({req_ready, resp_valid, mem_wr, mem_a, mem_dout, resp_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rr=%b rv=%b wr=%b a=%h d=%h rd=%h want=all0",
                     req_ready, resp_valid, mem_wr, mem_a, mem_dout, resp_data);
        end
        req_valid = '0; rst_in = 1'b0;
        last_gnt = NUM_CH - 1;
        @(negedge clk_in);
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL idle_no_ready got=%b want=0", req_ready);
        end
    endtask

    task automatic test_rr_alternate();
        int order[4];
        int ng;
        int seen;
        ng = 0;
        req_we = '0; req_size = '0; req_signed = '0;
        req_addr[0] = 32'h10; req_addr[1] = 32'h20;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        for (int k = 0; k < 200 && ng < 4; k++) begin
            @(negedge clk_in);
            for (int c = 0; c < NUM_CH; c++)
                if (req_ready[c]) begin order[ng] = c; ng++; end
        end
        req_valid = '0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk_in);
            if (resp_valid != '0) seen = 1;
        end
        total++;
        if (ng != 4) begin
            bad++; $display("FAIL rr_grant_count got=%0d want=4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order[i] != (i % 2)) begin
                    bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], i % 2);
                end
            end
            last_gnt = order[3];
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_word_load();
        int a, r;
        logic [31:0] d;
        do_txn(1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h44332211, a, r, d);
        model_store(32'h100, 2'd2, 32'h44332211);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, a, r, d);
        total++;
        if (r - a != 6) begin bad++; $display("FAIL word_load_latency got=%0d want=6", r - a); end
        total++;
        if (d !== 32'h44332211) begin bad++; $display("FAIL word_load_data got=%h want=44332211", d); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_a[(a + 1 + i) % 4096] !== 32'h100 + 32'(i) || log_wr[(a + 1 + i) % 4096] !== 1'b0) begin
                bad++;
                $display("FAIL word_load_addr[%0d] got=%h wr=%b want=%h wr=0", i,
                         log_a[(a + 1 + i) % 4096], log_wr[(a + 1 + i) % 4096], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_sign_ext();
        int a, r;
        logic [31:0] d;
        do_txn(2, 1'b1, 2'd0, 1'b0, 32'h200, 32'h80, a, r, d);
        model_store(32'h200, 2'd0, 32'h80);
        do_txn(0, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0, a, r, d);
        total++;
        if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL signed_byte got=%h want=ffffff80", d); end
        total++;
        if (r - a != 3) begin bad++; $display("FAIL byte_load_latency got=%0d want=3", r - a); end
        do_txn(1, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0, a, r, d);
        total++;
        if (d !== 32'h00000080) begin bad++; $display("FAIL unsigned_byte got=%h want=00000080", d); end
    endtask

    task automatic test_half_store();
        int a, r;
        logic [31:0] d;
        do_txn(0, 1'b1, 2'd1, 1'b0, 32'h3FF, 32'h1234BEEF, a, r, d);
        model_store(32'h3FF, 2'd1, 32'h1234BEEF);
        total++;
        if (r - a != 3 || d !== 32'h0) begin
            bad++; $display("FAIL half_store_resp got lat=%0d data=%h want lat=3 data=0", r - a, d);
        end
        total++;
        if (log_a[(a + 1) % 4096] !== 32'h3FF || log_d[(a + 1) % 4096] !== 8'hEF || log_wr[(a + 1) % 4096] !== 1'b1 ||
            log_a[(a + 2) % 4096] !== 32'h400 || log_d[(a + 2) % 4096] !== 8'hBE || log_wr[(a + 2) % 4096] !== 1'b1) begin
            bad++;
            $display("FAIL half_store_bus got %h:%h %h:%h want 3ff:ef 400:be",
                     log_a[(a + 1) % 4096], log_d[(a + 1) % 4096], log_a[(a + 2) % 4096], log_d[(a + 2) % 4096]);
        end
        @(negedge clk_in);
        total++;
        if (ram[18'h3FF] !== 8'hEF || ram[18'h400] !== 8'hBE) begin
            bad++; $display("FAIL half_store_ram got=%h%h want=beef", ram[18'h400], ram[18'h3FF]);
        end
    endtask

    task automatic test_flush();
        int a, a2, r;
        int stray;
        logic [31:0] d;
        a = -1; a2 = -1; r = -1; stray = 0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2;
        req_signed[0] = 1'b0; req_addr[0] = 32'h100;
        for (int k = 0; k < 60 && a < 0; k++) begin
            @(negedge clk_in);
            if (req_ready[0]) a = cyc;
        end
        req_valid[0] = 1'b0;
        @(posedge clk_in); #1 flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        // Follow-up byte load on ch1 must be granted right away
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd0;
        req_signed[1] = 1'b0; req_addr[1] = 32'h201;
        @(negedge clk_in);
        total++;
        if (mem_a !== '0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL flush_idle_bus got a=%h wr=%b want a=0 wr=0", mem_a, mem_wr);
        end
        for (int k = 0; k < 12; k++) begin
            if (resp_valid[0]) stray++;
            if (req_ready[1] && a2 < 0) begin a2 = cyc; req_valid[1] = 1'b0; end
            if (resp_valid[1] && r < 0) begin r = cyc; d = resp_data; end
            @(negedge clk_in);
        end
        req_valid[1] = 1'b0;
        total++;
        if (stray != 0) begin bad++; $display("FAIL flush_no_resp got=%0d want=0", stray); end
        total++;
        if (a2 != a + 3) begin bad++; $display("FAIL flush_regrant got=%0d want=%0d", a2 - a, 3); end
        total++;
        if (r < 0 || d !== model_load(32'h201, 2'd0, 1'b0)) begin
            bad++; $display("FAIL flush_next_load got=%h want=%h", d, model_load(32'h201, 2'd0, 1'b0));
        end
        if (a2 >= 0) last_gnt = 1;
        // A store accepted the same way ignores the flush
        a = -1; r = -1;
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd1;
        req_addr[2] = 32'h500; req_wdata[2] = 32'h0000CAFE;
        for (int k = 0; k < 60 && a < 0; k++) begin
            @(negedge clk_in);
            if (req_ready[2]) a = cyc;
        end
        req_valid[2] = 1'b0;
        @(posedge clk_in); #1 flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        for (int k = 0; k < 20 && r < 0; k++) begin
            @(negedge clk_in);
            if (resp_valid[2]) r = cyc;
        end
        model_store(32'h500, 2'd1, 32'h0000CAFE);
        last_gnt = 2;
        total++;
        if (r != a + 3) begin bad++; $display("FAIL flush_store_done got=%0d want=3", r - a); end
        do_txn(0, 1'b0, 2'd1, 1'b0, 32'h500, 32'h0, a, r, d);
        total++;
        if (d !== 32'h0000CAFE) begin bad++; $display("FAIL flush_store_data got=%h want=0000cafe", d); end
    endtask

    task automatic test_rdy_freeze();
        int a, r;
        logic [31:0] d;
        a = -1; r = -1;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2;
        req_signed[1] = 1'b0; req_addr[1] = 32'h100;
        for (int k = 0; k < 60 && a < 0; k++) begin
            @(negedge clk_in);
            if (req_ready[1]) a = cyc;
        end
        req_valid[1] = 1'b0;
        @(posedge clk_in); #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rdy_in = 1'b1;
        for (int k = 0; k < 40 && r < 0; k++) begin
            @(negedge clk_in);
            if (resp_valid[1]) begin r = cyc; d = resp_data; end
        end
        last_gnt = 1;
        total++;
        if (r != a + 9 || d !== model_load(32'h100, 2'd2, 1'b0)) begin
            bad++; $display("FAIL rdy_freeze got lat=%0d data=%h want lat=9 data=%h", r - a, d,
                            model_load(32'h100, 2'd2, 1'b0));
        end
        total++;
        if (log_a[(a + 1) % 4096] !== 32'h100 || log_a[(a + 4) % 4096] !== 32'h100 ||
            log_a[(a + 5) % 4096] !== 32'h101) begin
            bad++; $display("FAIL rdy_hold_addr got %h %h %h want 100 100 101",
                            log_a[(a + 1) % 4096], log_a[(a + 4) % 4096], log_a[(a + 5) % 4096]);
        end
    endtask

    task automatic test_io_stall();
        int a, r;
        logic [31:0] d;
`ifdef MEMCTRL_IO_STALL_EN
        a = -1; r = -1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd0;
        req_addr[0] = 32'h30000; req_wdata[0] = 32'h5A;
        for (int k = 0; k < 60 && a < 0; k++) begin
            @(negedge clk_in);
            if (req_ready[0]) a = cyc;
        end
        req_valid[0] = 1'b0;
        io_buffer_full = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        io_buffer_full = 1'b0;
        for (int k = 0; k < 20 && r < 0; k++) begin
            @(negedge clk_in);
            if (resp_valid[0]) r = cyc;
        end
        model_store(32'h30000, 2'd0, 32'h5A);
        last_gnt = 0;
        total++;
        if (r != a + 5) begin bad++; $display("FAIL io_stall_latency got=%0d want=5", r - a); end
        total++;
        if (log_wr[(a + 1) % 4096] !== 1'b0 || log_wr[(a + 2) % 4096] !== 1'b0 || log_wr[(a + 3) % 4096] !== 1'b0 ||
            log_wr[(a + 4) % 4096] !== 1'b1 || log_a[(a + 4) % 4096] !== 32'h30000 || log_d[(a + 4) % 4096] !== 8'h5A) begin
            bad++; $display("FAIL io_stall_bus got wr=%b%b%b%b a=%h want wr=0001 a=30000",
                            log_wr[(a + 1) % 4096], log_wr[(a + 2) % 4096], log_wr[(a + 3) % 4096],
                            log_wr[(a + 4) % 4096], log_a[(a + 4) % 4096]);
        end
        // Just past the window: full buffer does not matter
        io_buffer_full = 1'b1;
        do_txn(1, 1'b1, 2'd0, 1'b0, 32'h30008, 32'h66, a, r, d);
        io_buffer_full = 1'b0;
        model_store(32'h30008, 2'd0, 32'h66);
        total++;
        if (r - a != 2) begin bad++; $display("FAIL io_outside_window got=%0d want=2", r - a); end
`else
        do_txn(0, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h5A, a, r, d);
        model_store(32'h30000, 2'd0, 32'h5A);
        total++;
        if (r - a != 2 || log_a[(a + 1) % 4096] !== 32'h30000 || log_wr[(a + 1) % 4096] !== 1'b1) begin
            bad++; $display("FAIL io_no_stall got lat=%0d a=%h want lat=2 a=30000",
                            r - a, log_a[(a + 1) % 4096]);
        end
`endif
    endtask

    task automatic test_rr_random();
        logic [NUM_CH-1:0] mask, got;
        int want, gch, r;
        logic [31:0] d;
        for (int it = 0; it < 20; it++) begin
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            want = -1;
            for (int i = 1; i <= NUM_CH && want < 0; i++)
                if (mask[(last_gnt + i) % NUM_CH]) want = (last_gnt + i) % NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                req_we[c] = 1'b0; req_size[c] = 2'd0; req_signed[c] = 1'b0;
                req_addr[c] = 32'h800 + 32'(c);
            end
            req_valid = mask;
            got = '0;
            for (int k = 0; k < 30 && got == '0; k++) begin
                @(negedge clk_in);
                got = req_ready;
            end
            req_valid = '0;
            total++;
            if (got !== NUM_CH'(1 << want)) begin
                bad++; $display("FAIL rr_pick mask=%b last=%0d got=%b want=%0d", mask, last_gnt, got, want);
            end
            gch = want;
            for (int c = 0; c < NUM_CH; c++) if (got[c]) gch = c;
            last_gnt = gch;
            r = -1;
            for (int k = 0; k < 20 && r < 0; k++) begin
                @(negedge clk_in);
                if (resp_valid[gch]) begin r = cyc; d = resp_data; end
            end
            total++;
            if (r < 0 || d !== model_load(32'h800 + 32'(gch), 2'd0, 1'b0)) begin
                bad++; $display("FAIL rr_data ch=%0d got=%h want=%h", gch, d,
                                model_load(32'h800 + 32'(gch), 2'd0, 1'b0));
            end
        end
    endtask

    task automatic test_random_traffic();
        int a, r, ch, n, sel;
        bit we, sg, bus_ok;
        logic [1:0] sz;
        logic [31:0] addr, wd, d, want;
        for (int it = 0; it < 120; it++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else if (sel < 3) addr = $urandom;
            else addr = 32'($urandom_range(0, 32'h3FFFF));
            n = nbytes(sz);
            want = we ? 32'h0 : model_load(addr, sz, sg);
            do_txn(ch, we, sz, sg, addr, wd, a, r, d);
            if (we) model_store(addr, sz, wd);
            total++;
            if (r - a != (we ? n + 1 : n + 2) || d !== want) begin
                bad++; $display("FAIL rand[%0d] we=%0d sz=%0d addr=%h got lat=%0d d=%h want lat=%0d d=%h",
                                it, we, sz, addr, r - a, d, we ? n + 1 : n + 2, want);
            end
            bus_ok = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (log_a[(a + 1 + i) % 4096] !== addr + 32'(i) || log_wr[(a + 1 + i) % 4096] !== we) bus_ok = 1'b0;
                if (we && log_d[(a + 1 + i) % 4096] !== wd[8*i +: 8]) bus_ok = 1'b0;
            end
            total++;
            if (!bus_ok) begin
                bad++; $display("FAIL rand_bus[%0d] addr=%h first_a=%h want=%h", it, addr,
                                log_a[(a + 1) % 4096], addr);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        req_valid = '0; req_we = '0; req_size = '0; req_signed = '0;
        req_addr = '0; req_wdata = '0;
`ifdef MEMCTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 262144; i++) shadow[i] = init_byte(i);
        @(negedge clk_in);
        test_reset();
        test_rr_alternate();
        test_word_load();
        test_sign_ext();
        test_half_store();
        test_flush();
        test_rdy_freeze();
        test_io_stall();
        test_rr_random();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
